// File: rtl/stereo_line_mux.sv
// Line-interleaving merger of the right/left camera FIFOs into one 16-bit stream.
// Define FRAME_HDR_EN to prefix each frame with a 16'hA55A / frame-count header.
module stereo_line_mux #(
    parameter int IM_X       = 1920,
    parameter int IM_Y       = 1080,
    parameter int COLOR_MODE = 1
) (
    input  logic        USB_CLK,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] r_data,
    input  logic        r_empty,
    output logic        r_rd,
    input  logic [15:0] l_data,
    input  logic        l_empty,
    output logic        l_rd,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol,
    output logic        busy
);

    localparam int WPL = IM_X * COLOR_MODE / 2;
    localparam int WCW = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int LCW = (IM_Y > 1) ? $clog2(IM_Y) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(WPL - 1);
    localparam logic [LCW-1:0] LINE_LAST = LCW'(IM_Y - 1);

`ifdef FRAME_HDR_EN
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, LINE_R, LINE_L} state_t;
`else
    typedef enum logic [1:0] {IDLE, LINE_R, LINE_L} state_t;
`endif

    state_t         state, state_nxt;
    logic [WCW-1:0] word_cnt, word_cnt_nxt;
    logic [LCW-1:0] line_cnt, line_cnt_nxt;
`ifdef FRAME_HDR_EN
    logic [15:0]    frame_cnt, frame_cnt_nxt;
`endif

    logic           load_ok;
    logic           load;
    logic [15:0]    ld_data;
    logic           ld_sof;
    logic           ld_eol;
    logic           word_last;

    // Gating with rst keeps FIFO acks from being issued for a load that reset discards.
    assign load_ok   = !rst && (!out_valid || out_ready);
    assign word_last = (word_cnt == WORD_LAST);
    assign busy      = (state != IDLE);

    always_ff @(posedge USB_CLK) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            line_cnt <= '0;
`ifdef FRAME_HDR_EN
            frame_cnt <= '0;
`endif
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            line_cnt <= line_cnt_nxt;
`ifdef FRAME_HDR_EN
            frame_cnt <= frame_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        line_cnt_nxt = line_cnt;
`ifdef FRAME_HDR_EN
        frame_cnt_nxt = frame_cnt;
`endif
        load    = 1'b0;
        ld_data = '0;
        ld_sof  = 1'b0;
        ld_eol  = 1'b0;
        r_rd    = 1'b0;
        l_rd    = 1'b0;

        case (state)
            IDLE: begin
                if (en && !r_empty && !l_empty) begin
`ifdef FRAME_HDR_EN
                    state_nxt = HDR0;
`else
                    state_nxt = LINE_R;
`endif
                end
            end
`ifdef FRAME_HDR_EN
            HDR0: begin
                if (load_ok) begin
                    load      = 1'b1;
                    ld_data   = 16'hA55A;
                    ld_sof    = 1'b1;
                    state_nxt = HDR1;
                end
            end
            HDR1: begin
                if (load_ok) begin
                    load      = 1'b1;
                    ld_data   = frame_cnt;
                    state_nxt = LINE_R;
                end
            end
`endif
            LINE_R: begin
                if (load_ok && !r_empty) begin
                    load    = 1'b1;
                    r_rd    = 1'b1;
                    ld_data = r_data;
                    ld_eol  = word_last;
`ifndef FRAME_HDR_EN
                    ld_sof  = (line_cnt == '0) && (word_cnt == '0);
`endif
                    if (word_last) begin
                        word_cnt_nxt = '0;
                        state_nxt    = LINE_L;
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end
            LINE_L: begin
                if (load_ok && !l_empty) begin
                    load    = 1'b1;
                    l_rd    = 1'b1;
                    ld_data = l_data;
                    ld_eol  = word_last;
                    if (word_last) begin
                        word_cnt_nxt = '0;
                        if (line_cnt == LINE_LAST) begin
                            line_cnt_nxt = '0;
`ifdef FRAME_HDR_EN
                            frame_cnt_nxt = frame_cnt + 16'd1;
`endif
                            state_nxt = IDLE;
                        end else begin
                            line_cnt_nxt = line_cnt + 1'b1;
                            state_nxt    = LINE_R;
                        end
                    end else begin
                        word_cnt_nxt = word_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge USB_CLK) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= ld_data;
            out_sof   <= ld_sof;
            out_eol   <= ld_eol;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/stereo_line_mux.md
Name: stereo_line_mux

Overview:
- Sits in the USB_CLK domain between the two per-camera capture FIFOs (right, left) and the USB write FSM.
- Merges the two camera streams into one 16-bit word stream, line-interleaved: line n of the right camera, then line n of the left camera, for IM_Y lines.
- Marks start-of-frame and end-of-line so the downstream FSM can place DMA packet and frame boundaries.
- Optionally prefixes each frame with a two-word header.

Parameters:
- IM_X, 1920, pixels per line per camera.
- IM_Y, 1080, lines per frame per camera.
- COLOR_MODE, 1, bytes per pixel: 1 = GRAY8, 2 = RGB565.
- WPL (localparam), IM_X*COLOR_MODE/2, 16-bit words per camera line. IM_X*COLOR_MODE must be even.

Ports:
- USB_CLK  in  1  sole clock.
- rst  in  1  synchronous reset, active-high.
- en  in  1  streaming enable, sampled only in IDLE.
- r_data  in  16  right FIFO show-ahead data, valid while r_empty=0.
- r_empty  in  1  right FIFO empty.
- r_rd  out  1  right FIFO read acknowledge, 1-cycle pulse per word.
- l_data  in  16  left FIFO show-ahead data.
- l_empty  in  1  left FIFO empty.
- l_rd  out  1  left FIFO read acknowledge.
- out_data  out  16  merged word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.
- out_sof  out  1  qualifies the first word of a frame (header word 0 if enabled).
- out_eol  out  1  qualifies the last word of each camera line.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; frame_cnt 0. Reset mid-frame aborts immediately, with no flush; any partially read line is lost.
- Output register: a single stage.
  - Load is allowed when `!out_valid || out_ready`.
  - out_valid is held, and out_data/out_sof/out_eol are held stable, until accepted.
- Latency: FIFO word to out_valid is 1 cycle. No bubbles while the source is non-empty and out_ready=1, giving 1 word/cycle.
- Read rule: the selected FIFO is read (x_rd=1) in the same cycle its word is loaded into the output register. x_rd is never asserted while x_empty=1. Only the FIFO selected by the current state is read; the other is never read.
- State machine:
  - IDLE: if en=1 and both r_empty=0 and l_empty=0, go to HDR0 if FRAME_HDR_EN is defined, otherwise LINE_R. Otherwise stay.
  - HDR0: load 16'hA55A with out_sof=1, then go to HDR1.
  - HDR1: load frame_cnt, then go to LINE_R.
  - LINE_R: load WPL words from the right FIFO. out_sof=1 on word 0 of line 0 only when there is no header. out_eol=1 on word WPL-1. After the word WPL-1 load, go to LINE_L.
  - LINE_L: load WPL words from the left FIFO. out_eol=1 on word WPL-1. After that load:
    - if line_cnt==IM_Y-1: line_cnt←0, frame_cnt←frame_cnt+1, go to IDLE;
    - else: line_cnt++, go to LINE_R.
- Counters:
  - word_cnt is $clog2(WPL) wide and resets to 0 on each line switch.
  - line_cnt is $clog2(IM_Y) wide.
  - frame_cnt is 16 bits and wraps 16'hFFFF→0.
- FIFO empty mid-line: stall with no load; out_valid drops once the held word is accepted. Resume on the next non-empty cycle. No data is inserted or dropped.
- Simultaneous events:
  - A load and an accept in the same cycle is legal and sustains throughput.
  - en deassert mid-frame is ignored; the frame completes and the block then stays in IDLE.
- busy=0 only in IDLE. A stalled frame holds busy=1 indefinitely; there is no timeout.

Optional Feature:
- Macro: FRAME_HDR_EN.
- Defined: HDR0/HDR1 exist. Each frame is 2 + 2*WPL*IM_Y words, and out_sof marks the 16'hA55A word.
- Undefined: HDR0/HDR1 and frame_cnt logic are removed. Each frame is 2*WPL*IM_Y words, and out_sof marks the first right-camera word.

Test Plan (IM_X=8, IM_Y=2, COLOR_MODE=1, so WPL=4):
- Both FIFOs preloaded (R: 0x1000.., L: 0x2000..), en=1, out_ready=1 → output is R0-3, L0-3, R4-7, L4-7. out_eol is set on words 3, 7, 11 and 15. The block returns to IDLE with busy=0. Header off: 16 words, out_sof on 0x1000.
- FRAME_HDR_EN defined, run 2 frames → frame 1 is 0xA55A, 0x0000, then data; frame 2 is 0xA55A, 0x0001, then data. out_sof is set on each 0xA55A word. Force frame_cnt to 0xFFFF → next header reads 0x0000.
- out_ready toggled randomly → out_data and all flags held while out_valid && !out_ready. Sequence identical to the first scenario; each r_rd/l_rd pulse count equals 8 per frame.
- r_empty forced high for 5 cycles after R word 1 → no r_rd, out_valid falls, no l_rd occurs. The stream resumes with R2 and the sequence is unchanged.
- rst pulsed mid-LINE_L → next cycle all outputs 0, busy=0. The next frame restarts at line 0 and, if enabled, with the header frame count 0.
- en=1 with only l_empty=0 → remains in IDLE, no reads. Once r_empty falls → frame starts within 1 cycle.
